// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush sequencer for the 5-stage OTTER pipeline.
// Ports: CLK, RST_N (async active-low); load_use_D, branch_taken_E, mdu_req_E,
//   mdu_done, dmem_wait_M in; stall_F/D/E/M, flush_D/E/M/W, mdu_go, mdu_abort,
//   stall_cycles out. Outputs are Mealy (state + inputs), forced to 0 during reset.
// Option: PIPE_STALL_CNT_EN builds the saturating stall_F cycle counter;
//   otherwise stall_cycles is tied to 0.
module pipe_stall_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load_use_D,
    input  logic             branch_taken_E,
    input  logic             mdu_req_E,
    input  logic             mdu_done,
    input  logic             dmem_wait_M,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_M,
    output logic             flush_W,
    output logic             mdu_go,
    output logic             mdu_abort,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic {RUN, MDU_WAIT} state_t;
    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       done_q, done_d;
    logic [9:0] o;
    always_comb begin
        o          = '0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        done_d     = done_q;
        if (dmem_wait_M) begin
            o = 10'b1111_0001_00;
            if (state_q == MDU_WAIT && mdu_done) done_d = 1'b1;
        end else if (state_q == RUN) begin
            if (branch_taken_E) begin
                o = 10'b0000_1100_00;
            end else if (mdu_req_E) begin
                o          = 10'b1110_0010_10;
                state_d    = MDU_WAIT;
                wait_cnt_d = '0;
                done_d     = 1'b0;
            end else if (load_use_D) begin
                o = 10'b1100_0100_00;
            end
        end else if (mdu_done || done_q) begin
            state_d = RUN;
            done_d  = 1'b0;
        end else if (wait_cnt_q == 8'(MDU_TIMEOUT - 1)) begin
            o       = 10'b0000_0000_01;
            state_d = RUN;
        end else begin
            o          = 10'b1110_0010_00;
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            done_q     <= done_d;
        end
    end
    // Gate with RST_N so every control output drops the instant reset asserts.
    assign {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W,
            mdu_go, mdu_abort} = RST_N ? o : '0;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign cnt_d = (stall_F && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign stall_cycles = cnt_q;
`else
    assign stall_cycles = '0;
`endif
endmodule
